// File: rtl/panic_perf_pkg.sv
// Register map and read-port constants for the PANIC RX performance monitor.
package panic_perf_pkg;

    localparam int RD_WIDTH = 32;

    localparam logic [7:0] ADDR_CYCLE_LO      = 8'h00;
    localparam logic [7:0] ADDR_CYCLE_HI      = 8'h01;
    localparam logic [7:0] ADDR_IN_FRAMES     = 8'h02;
    localparam logic [7:0] ADDR_OUT_FRAMES    = 8'h03;
    localparam logic [7:0] ADDR_IN_PKTS       = 8'h04;
    localparam logic [7:0] ADDR_OUT_PKTS      = 8'h05;
    localparam logic [7:0] ADDR_WINDOW_NUM    = 8'h06;
    localparam logic [7:0] ADDR_LAST_OUT      = 8'h07;
    localparam logic [7:0] ADDR_MAX_OUT       = 8'h08;
    localparam logic [7:0] ADDR_LAST_PK_SUM   = 8'h09;
    localparam logic [7:0] ADDR_LAST_PK_CNT   = 8'h0A;
    localparam logic [7:0] ADDR_OTHER_FRAMES  = 8'h0B;

    localparam logic [7:0] BASE_LAST_IN       = 8'h10;
    localparam logic [7:0] BASE_LAST_BYTES    = 8'h20;
    localparam logic [7:0] BASE_MAX_IN        = 8'h30;

endpackage

// File: rtl/perf_popcount.sv
// Combinational byte count of a tkeep vector.
module perf_popcount #(
    parameter int KEEP_WIDTH = 32,
    parameter int COUNT_WIDTH = $clog2(KEEP_WIDTH + 1)
) (
    input  logic [KEEP_WIDTH-1:0]  keep,
    output logic [COUNT_WIDTH-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            count = count + COUNT_WIDTH'(keep[i]);
        end
    end

endmodule

// File: rtl/panic_perf_monitor.sv
// Passive ingress/egress AXI-stream monitor: lifetime totals, windowed per-class
// counts with snapshots and maxima, and a 1-cycle-latency register read port.
module panic_perf_monitor
    import panic_perf_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = 256,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int NUM_CLASS       = 5,
    parameter int CLASS_WIDTH     = 5,
    parameter int WINDOW_LOG2     = 10,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AXIS_KEEP_WIDTH-1:0] s_rx_axis_tkeep,
    input  logic                       s_rx_axis_tvalid,
    input  logic                       s_rx_axis_tready,
    input  logic                       s_rx_axis_tlast,
    input  logic [CLASS_WIDTH-1:0]     s_flow_class,
    input  logic [15:0]                s_pk_len,
    input  logic                       m_rx_axis_tvalid,
    input  logic                       m_rx_axis_tready,
    input  logic                       m_rx_axis_tlast,
    input  logic                       clear,
    input  logic                       rd_en,
    input  logic [7:0]                 rd_addr,
    output logic [RD_WIDTH-1:0]        rd_data,
    output logic                       rd_valid
);

    localparam int BYTE_W = $clog2(AXIS_KEEP_WIDTH + 1);
    typedef logic [CNT_WIDTH-1:0] cnt_t;

    logic              in_beat, out_beat, in_pkt, out_pkt, class_ok, boundary;
    logic [BYTE_W-1:0] beat_bytes;
    logic [63:0]       cycle_cnt;
    logic [WINDOW_LOG2-1:0] win_cnt;
    logic [RD_WIDTH-1:0]    rd_mux;

    cnt_t in_frames, out_frames, in_pkts, out_pkts, other_frames, window_num;
    cnt_t win_in [NUM_CLASS];
    cnt_t win_bytes [NUM_CLASS];
    cnt_t nxt_in [NUM_CLASS];
    cnt_t nxt_bytes [NUM_CLASS];
    cnt_t last_in [NUM_CLASS];
    cnt_t last_bytes [NUM_CLASS];
    cnt_t max_in [NUM_CLASS];
    cnt_t win_out, win_pk_sum, win_pk_cnt;
    cnt_t nxt_out, nxt_pk_sum, nxt_pk_cnt;
    cnt_t last_out, max_out, last_pk_sum, last_pk_cnt;

    // Wide enough for any increment up to 32 bits, so saturation is exact.
    function automatic cnt_t sat_add(input cnt_t a, input logic [31:0] b);
        logic [CNT_WIDTH+32:0] s;
        s = {33'd0, a} + {{(CNT_WIDTH + 1){1'b0}}, b};
        if (s > {33'd0, {CNT_WIDTH{1'b1}}}) return '1;
        return s[CNT_WIDTH-1:0];
    endfunction

    function automatic logic [RD_WIDTH-1:0] ext(input cnt_t v);
        return RD_WIDTH'(v);
    endfunction

    perf_popcount #(.KEEP_WIDTH(AXIS_KEEP_WIDTH), .COUNT_WIDTH(BYTE_W)) u_popcount (
        .keep  (s_rx_axis_tkeep),
        .count (beat_bytes)
    );

    assign in_beat  = s_rx_axis_tvalid && s_rx_axis_tready;
    assign out_beat = m_rx_axis_tvalid && m_rx_axis_tready;
    assign in_pkt   = in_beat && s_rx_axis_tlast;
    assign out_pkt  = out_beat && m_rx_axis_tlast;
    assign class_ok = {1'b0, s_flow_class} < (CLASS_WIDTH + 1)'(NUM_CLASS);
    assign boundary = &win_cnt;

    // Window values including this cycle's beat; they feed both the live
    // counters and, on a boundary, the snapshots.
    always_comb begin
        for (int c = 0; c < NUM_CLASS; c++) begin
            nxt_in[c]    = win_in[c];
            nxt_bytes[c] = win_bytes[c];
            if (in_beat && class_ok && s_flow_class == CLASS_WIDTH'(c)) begin
                nxt_in[c]    = sat_add(win_in[c], 32'd1);
                nxt_bytes[c] = sat_add(win_bytes[c], 32'(beat_bytes));
            end
        end
        nxt_out    = out_beat ? sat_add(win_out, 32'd1) : win_out;
        nxt_pk_sum = in_pkt ? sat_add(win_pk_sum, 32'(s_pk_len)) : win_pk_sum;
        nxt_pk_cnt = in_pkt ? sat_add(win_pk_cnt, 32'd1) : win_pk_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cycle_cnt    <= '0;
            win_cnt      <= '0;
            in_frames    <= '0;
            out_frames   <= '0;
            in_pkts      <= '0;
            out_pkts     <= '0;
            other_frames <= '0;
            window_num   <= '0;
            win_out      <= '0;
            win_pk_sum   <= '0;
            win_pk_cnt   <= '0;
            last_out     <= '0;
            max_out      <= '0;
            last_pk_sum  <= '0;
            last_pk_cnt  <= '0;
            for (int c = 0; c < NUM_CLASS; c++) begin
                win_in[c]     <= '0;
                win_bytes[c]  <= '0;
                last_in[c]    <= '0;
                last_bytes[c] <= '0;
                max_in[c]     <= '0;
            end
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
            win_cnt   <= win_cnt + 1'b1;
            if (in_beat)             in_frames    <= sat_add(in_frames, 32'd1);
            if (out_beat)            out_frames   <= sat_add(out_frames, 32'd1);
            if (in_pkt)              in_pkts      <= sat_add(in_pkts, 32'd1);
            if (out_pkt)             out_pkts     <= sat_add(out_pkts, 32'd1);
            if (in_beat && !class_ok) other_frames <= sat_add(other_frames, 32'd1);
            if (boundary) begin
                for (int c = 0; c < NUM_CLASS; c++) begin
                    last_in[c]    <= nxt_in[c];
                    last_bytes[c] <= nxt_bytes[c];
                    if (nxt_in[c] > max_in[c]) max_in[c] <= nxt_in[c];
                    win_in[c]     <= '0;
                    win_bytes[c]  <= '0;
                end
                last_out    <= nxt_out;
                if (nxt_out > max_out) max_out <= nxt_out;
                last_pk_sum <= nxt_pk_sum;
                last_pk_cnt <= nxt_pk_cnt;
                win_out     <= '0;
                win_pk_sum  <= '0;
                win_pk_cnt  <= '0;
                window_num  <= sat_add(window_num, 32'd1);
            end else begin
                for (int c = 0; c < NUM_CLASS; c++) begin
                    win_in[c]    <= nxt_in[c];
                    win_bytes[c] <= nxt_bytes[c];
                end
                win_out    <= nxt_out;
                win_pk_sum <= nxt_pk_sum;
                win_pk_cnt <= nxt_pk_cnt;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (rd_addr)
            ADDR_CYCLE_LO:     rd_mux = cycle_cnt[31:0];
            ADDR_CYCLE_HI:     rd_mux = cycle_cnt[63:32];
            ADDR_IN_FRAMES:    rd_mux = ext(in_frames);
            ADDR_OUT_FRAMES:   rd_mux = ext(out_frames);
            ADDR_IN_PKTS:      rd_mux = ext(in_pkts);
            ADDR_OUT_PKTS:     rd_mux = ext(out_pkts);
            ADDR_WINDOW_NUM:   rd_mux = ext(window_num);
            ADDR_LAST_OUT:     rd_mux = ext(last_out);
            ADDR_MAX_OUT:      rd_mux = ext(max_out);
            ADDR_LAST_PK_SUM:  rd_mux = ext(last_pk_sum);
            ADDR_LAST_PK_CNT:  rd_mux = ext(last_pk_cnt);
            ADDR_OTHER_FRAMES: rd_mux = ext(other_frames);
            default:           rd_mux = '0;
        endcase
        for (int c = 0; c < NUM_CLASS; c++) begin
            if (rd_addr == BASE_LAST_IN + 8'(c))    rd_mux = ext(last_in[c]);
            if (rd_addr == BASE_LAST_BYTES + 8'(c)) rd_mux = ext(last_bytes[c]);
            if (rd_addr == BASE_MAX_IN + 8'(c))     rd_mux = ext(max_in[c]);
        end
    end

    // Software clear leaves the read port alone so a read issued with it
    // still returns the pre-clear value.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= rd_mux;
        end
    end

endmodule
